sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of a single-outstanding-request SDRAM controller.
// Each port holds one request in a pending slot; a request edge that finds the slot full sets a sticky overrun flag.
module sdram_port_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] a_address,
  input  logic [7:0]  a_to_mem,
  input  logic        a_req,
  input  logic        a_wren,
  output logic [7:0]  a_from_mem,
  output logic        a_ready,
  output logic        a_overrun,
  input  logic [20:0] b_address,
  input  logic [7:0]  b_to_mem,
  input  logic        b_req,
  input  logic        b_wren,
  output logic [7:0]  b_from_mem,
  output logic        b_ready,
  output logic        b_overrun,
  output logic [20:0] mem_address,
  output logic [7:0]  to_mem,
  output logic        mem_req,
  output logic        mem_wren,
  input  logic [7:0]  from_mem,
  input  logic        mem_ready,
  output logic        busy,
  output logic        owner
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state;
  logic        a_req_q, b_req_q, ready_q;
  logic        a_pending, b_pending;
  logic [20:0] a_addr_h, b_addr_h;
  logic [7:0]  a_dat_h, b_dat_h;
  logic        a_wren_h, b_wren_h;
  logic        a_edge, b_edge, done, grant, pick_b;

  assign a_edge = a_req & ~a_req_q;
  assign b_edge = b_req & ~b_req_q;
  assign done   = (state == S_WAIT) & mem_ready & ~ready_q;
  assign grant  = (state == S_IDLE) & (a_pending | b_pending);
  // On a tie B wins only in round-robin mode and only when A held the last grant.
  assign pick_b = b_pending & (~a_pending | ((FIXED_PRIORITY == 0) & ~owner));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_req_q     <= 1'b0;
      b_req_q     <= 1'b0;
      ready_q     <= 1'b0;
      a_pending   <= 1'b0;
      b_pending   <= 1'b0;
      a_addr_h    <= '0;
      b_addr_h    <= '0;
      a_dat_h     <= '0;
      b_dat_h     <= '0;
      a_wren_h    <= 1'b0;
      b_wren_h    <= 1'b0;
      a_from_mem  <= '0;
      b_from_mem  <= '0;
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      a_overrun   <= 1'b0;
      b_overrun   <= 1'b0;
      mem_address <= '0;
      to_mem      <= '0;
      mem_req     <= 1'b0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      owner       <= 1'b1;
    end else begin
      a_req_q <= a_req;
      b_req_q <= b_req;
      ready_q <= mem_ready;
      mem_req <= 1'b0;
      a_ready <= 1'b0;
      b_ready <= 1'b0;

      if (state == S_IDLE) begin
        if (grant) begin
          mem_req <= 1'b1;
          busy    <= 1'b1;
          state   <= S_WAIT;
          if (pick_b) begin
            mem_address <= b_addr_h;
            to_mem      <= b_dat_h;
            mem_wren    <= b_wren_h;
            owner       <= 1'b1;
            b_pending   <= 1'b0;
          end else begin
            mem_address <= a_addr_h;
            to_mem      <= a_dat_h;
            mem_wren    <= a_wren_h;
            owner       <= 1'b0;
            a_pending   <= 1'b0;
          end
        end
      end else if (done) begin
        busy  <= 1'b0;
        state <= S_IDLE;
        if (owner) begin
          b_ready <= 1'b1;
          if (!mem_wren) b_from_mem <= from_mem;
        end else begin
          a_ready <= 1'b1;
          if (!mem_wren) a_from_mem <= from_mem;
        end
      end

      // Intake never collides with the grant clear: a grant needs the slot already full.
      if (a_edge) begin
        if (a_pending) begin
          a_overrun <= 1'b1;
        end else begin
          a_pending <= 1'b1;
          a_addr_h  <= a_address;
          a_dat_h   <= a_to_mem;
          a_wren_h  <= a_wren;
        end
      end
      if (b_edge) begin
        if (b_pending) begin
          b_overrun <= 1'b1;
        end else begin
          b_pending <= 1'b1;
          b_addr_h  <= b_address;
          b_dat_h   <= b_to_mem;
          b_wren_h  <= b_wren;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: round-robin and fixed-priority instances against a transaction-level reference.
module tb_sdram_port_arbiter;

  typedef struct packed {
    logic [20:0] addr;
    logic [7:0]  dat;
    logic        wr;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [20:0] a_address_i [2];
  logic [20:0] b_address_i [2];
  logic [7:0]  a_to_mem_i [2];
  logic [7:0]  b_to_mem_i [2];
  logic        a_req_i [2];
  logic        b_req_i [2];
  logic        a_wren_i [2];
  logic        b_wren_i [2];
  logic [7:0]  from_mem_i;
  logic        rsp_rdy [2];
  logic        extra_rdy;

  logic [7:0]  a_from_mem_o [2];
  logic [7:0]  b_from_mem_o [2];
  logic        a_ready_o [2];
  logic        b_ready_o [2];
  logic        a_overrun_o [2];
  logic        b_overrun_o [2];
  logic [20:0] mem_address_o [2];
  logic [7:0]  to_mem_o [2];
  logic        mem_req_o [2];
  logic        mem_wren_o [2];
  logic        busy_o [2];
  logic        owner_o [2];

  sdram_port_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_address(a_address_i[0]), .a_to_mem(a_to_mem_i[0]), .a_req(a_req_i[0]), .a_wren(a_wren_i[0]),
    .a_from_mem(a_from_mem_o[0]), .a_ready(a_ready_o[0]), .a_overrun(a_overrun_o[0]),
    .b_address(b_address_i[0]), .b_to_mem(b_to_mem_i[0]), .b_req(b_req_i[0]), .b_wren(b_wren_i[0]),
    .b_from_mem(b_from_mem_o[0]), .b_ready(b_ready_o[0]), .b_overrun(b_overrun_o[0]),
    .mem_address(mem_address_o[0]), .to_mem(to_mem_o[0]), .mem_req(mem_req_o[0]), .mem_wren(mem_wren_o[0]),
    .from_mem(from_mem_i), .mem_ready(rsp_rdy[0] | extra_rdy),
    .busy(busy_o[0]), .owner(owner_o[0])
  );

  sdram_port_arbiter #(.FIXED_PRIORITY(1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .a_address(a_address_i[1]), .a_to_mem(a_to_mem_i[1]), .a_req(a_req_i[1]), .a_wren(a_wren_i[1]),
    .a_from_mem(a_from_mem_o[1]), .a_ready(a_ready_o[1]), .a_overrun(a_overrun_o[1]),
    .b_address(b_address_i[1]), .b_to_mem(b_to_mem_i[1]), .b_req(b_req_i[1]), .b_wren(b_wren_i[1]),
    .b_from_mem(b_from_mem_o[1]), .b_ready(b_ready_o[1]), .b_overrun(b_overrun_o[1]),
    .mem_address(mem_address_o[1]), .to_mem(to_mem_o[1]), .mem_req(mem_req_o[1]), .mem_wren(mem_wren_o[1]),
    .from_mem(from_mem_i), .mem_ready(rsp_rdy[1] | extra_rdy),
    .busy(busy_o[1]), .owner(owner_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // ---------------- reference model (port index 0 = A, 1 = B) ----------------
  bit          m_prev_req [2][2];
  bit          m_prev_rdy [2];
  bit          m_pend [2][2];
  txn_t        m_slot [2][2];
  bit          m_busy [2];
  bit          m_owner [2];
  txn_t        m_cur [2];
  bit          m_memreq [2];
  bit          m_rdy [2][2];
  logic [7:0]  m_rdata [2][2];
  bit          m_ovr [2][2];

  function automatic bit port_req(int k, int p);
    return (p == 0) ? a_req_i[k] : b_req_i[k];
  endfunction

  function automatic txn_t port_txn(int k, int p);
    txn_t t;
    if (p == 0) t = '{addr: a_address_i[k], dat: a_to_mem_i[k], wr: a_wren_i[k]};
    else        t = '{addr: b_address_i[k], dat: b_to_mem_i[k], wr: b_wren_i[k]};
    return t;
  endfunction

  task automatic model_reset(int k);
    for (int p = 0; p < 2; p++) begin
      m_prev_req[k][p] = 0; m_pend[k][p] = 0; m_slot[k][p] = '0;
      m_rdy[k][p] = 0; m_rdata[k][p] = '0; m_ovr[k][p] = 0;
    end
    m_prev_rdy[k] = 0; m_busy[k] = 0; m_owner[k] = 1; m_cur[k] = '0; m_memreq[k] = 0;
  endtask

  task automatic model_step(int k);
    bit e [2];
    bit was_pend [2];
    bit rdy_in;
    int w;
    rdy_in = rsp_rdy[k] | extra_rdy;
    for (int p = 0; p < 2; p++) begin
      e[p] = port_req(k, p) && !m_prev_req[k][p];
      was_pend[p] = m_pend[k][p];
      m_rdy[k][p] = 0;
    end
    m_memreq[k] = 0;
    if (m_busy[k]) begin
      if (rdy_in && !m_prev_rdy[k]) begin
        m_rdy[k][m_owner[k]] = 1;
        if (!m_cur[k].wr) m_rdata[k][m_owner[k]] = from_mem_i;
        m_busy[k] = 0;
      end
    end else if (was_pend[0] || was_pend[1]) begin
      if (was_pend[0] && was_pend[1]) w = (k == 1) ? 0 : (m_owner[k] ? 0 : 1);
      else                            w = was_pend[1] ? 1 : 0;
      m_cur[k] = m_slot[k][w];
      m_memreq[k] = 1;
      m_busy[k] = 1;
      m_owner[k] = (w == 1);
      m_pend[k][w] = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (e[p]) begin
        if (was_pend[p]) m_ovr[k][p] = 1;
        else begin
          m_pend[k][p] = 1;
          m_slot[k][p] = port_txn(k, p);
        end
      end
      m_prev_req[k][p] = port_req(k, p);
    end
    m_prev_rdy[k] = rdy_in;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else        model_step(k);
    end
  end

  // ---------------- controller responder ----------------
  int rsp_delay;
  int rsp_cnt [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rsp_cnt[k] = 0;
        rsp_rdy[k] = 1'b0;
      end else begin
        rsp_rdy[k] = 1'b0;
        if (rsp_cnt[k] > 0) begin
          rsp_cnt[k]--;
          if (rsp_cnt[k] == 0) rsp_rdy[k] = 1'b1;
        end
        if (mem_req_o[k]) rsp_cnt[k] = (rsp_delay > 0) ? rsp_delay : int'($urandom_range(1, 5));
      end
    end
  end

  // ---------------- observation log ----------------
  int   gcount [2];
  int   rdy_cnt [2][2];
  bit   g_own [2][$];
  txn_t g_txn [2][$];

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      gcount[k] = 0; rdy_cnt[k][0] = 0; rdy_cnt[k][1] = 0;
      g_own[k].delete(); g_txn[k].delete();
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mem_req",     k, 32'(mem_req_o[k]),     32'(m_memreq[k]));
      chk("mem_address", k, 32'(mem_address_o[k]), 32'(m_cur[k].addr));
      chk("to_mem",      k, 32'(to_mem_o[k]),      32'(m_cur[k].dat));
      chk("mem_wren",    k, 32'(mem_wren_o[k]),    32'(m_cur[k].wr));
      chk("busy",        k, 32'(busy_o[k]),        32'(m_busy[k]));
      chk("owner",       k, 32'(owner_o[k]),       32'(m_owner[k]));
      chk("a_ready",     k, 32'(a_ready_o[k]),     32'(m_rdy[k][0]));
      chk("b_ready",     k, 32'(b_ready_o[k]),     32'(m_rdy[k][1]));
      chk("a_from_mem",  k, 32'(a_from_mem_o[k]),  32'(m_rdata[k][0]));
      chk("b_from_mem",  k, 32'(b_from_mem_o[k]),  32'(m_rdata[k][1]));
      chk("a_overrun",   k, 32'(a_overrun_o[k]),   32'(m_ovr[k][0]));
      chk("b_overrun",   k, 32'(b_overrun_o[k]),   32'(m_ovr[k][1]));
      if (mem_req_o[k] === 1'b1) begin
        gcount[k]++;
        g_own[k].push_back(owner_o[k]);
        g_txn[k].push_back('{addr: mem_address_o[k], dat: to_mem_o[k], wr: mem_wren_o[k]});
      end
      if (a_ready_o[k] === 1'b1) rdy_cnt[k][0]++;
      if (b_ready_o[k] === 1'b1) rdy_cnt[k][1]++;
    end
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_req(int k, int p, logic v);
    if (p == 0) a_req_i[k] = v;
    else        b_req_i[k] = v;
  endtask

  task automatic set_fields(int k, int p, logic [20:0] addr, logic [7:0] dat, logic wr);
    if (p == 0) begin a_address_i[k] = addr; a_to_mem_i[k] = dat; a_wren_i[k] = wr; end
    else        begin b_address_i[k] = addr; b_to_mem_i[k] = dat; b_wren_i[k] = wr; end
  endtask

  task automatic drive_both(int p, logic v, logic [20:0] addr, logic [7:0] dat, logic wr);
    for (int k = 0; k < 2; k++) begin
      set_fields(k, p, addr, dat, wr);
      set_req(k, p, v);
    end
  endtask

  task automatic req_both(int p, logic v);
    for (int k = 0; k < 2; k++) set_req(k, p, v);
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_req",  k, 32'(mem_req_o[k]),     32'd0);
      chk("rst_mem_wren", k, 32'(mem_wren_o[k]),    32'd0);
      chk("rst_mem_addr", k, 32'(mem_address_o[k]), 32'd0);
      chk("rst_to_mem",   k, 32'(to_mem_o[k]),      32'd0);
      chk("rst_ready",    k, 32'({a_ready_o[k], b_ready_o[k]}), 32'd0);
      chk("rst_from_mem", k, 32'({a_from_mem_o[k], b_from_mem_o[k]}), 32'd0);
      chk("rst_overrun",  k, 32'({a_overrun_o[k], b_overrun_o[k]}), 32'd0);
      chk("rst_busy",     k, 32'(busy_o[k]),        32'd0);
      chk("rst_owner",    k, 32'(owner_o[k]),       32'd1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    extra_rdy = 1'b0;
    for (int p = 0; p < 2; p++) drive_both(p, 1'b0, '0, '0, 1'b0);
    cycles(2);
    chk_reset_outputs();
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    rst_n = 1'b1;
    extra_rdy = 1'b0;
    from_mem_i = '0;
    rsp_delay = 3;
    for (int p = 0; p < 2; p++) drive_both(p, 1'b0, '0, '0, 1'b0);
    #1;

    // Single read on A
    do_reset();
    from_mem_i = 8'h5A;
    drive_both(0, 1'b1, 21'h0ABCD, 8'h00, 1'b0);
    cyc();
    chk("lat_no_grant_yet", 0, 32'(mem_req_o[0]), 32'd0);
    cyc();
    chk("rd_mem_req",  0, 32'(mem_req_o[0]),     32'd1);
    chk("rd_mem_addr", 0, 32'(mem_address_o[0]), 32'h0ABCD);
    chk("rd_mem_wren", 0, 32'(mem_wren_o[0]),    32'd0);
    req_both(0, 1'b0);
    cyc();
    chk("rd_req_one_cycle", 0, 32'(mem_req_o[0]), 32'd0);
    cycles(10);
    chk("rd_from_mem",  0, 32'(a_from_mem_o[0]), 32'h5A);
    chk("rd_ready_cnt", 0, 32'(rdy_cnt[0][0]),   32'd1);
    chk("rd_grants",    0, 32'(gcount[0]),       32'd1);

    // Simultaneous A write and B read after reset: A first, then B
    do_reset();
    drive_both(0, 1'b1, 21'h00010, 8'h11, 1'b1);
    drive_both(1, 1'b1, 21'h1FFFF, 8'h00, 1'b0);
    cyc();
    req_both(0, 1'b0);
    req_both(1, 1'b0);
    cycles(20);
    for (int k = 0; k < 2; k++) begin
      chk("tie_grants", k, 32'(gcount[k]), 32'd2);
      if (g_own[k].size() >= 2) begin
        chk("tie_first_owner",  k, 32'(g_own[k][0]),      32'd0);
        chk("tie_first_addr",   k, 32'(g_txn[k][0].addr), 32'h00010);
        chk("tie_first_data",   k, 32'(g_txn[k][0].dat),  32'h11);
        chk("tie_first_wren",   k, 32'(g_txn[k][0].wr),   32'd1);
        chk("tie_second_owner", k, 32'(g_own[k][1]),      32'd1);
        chk("tie_second_addr",  k, 32'(g_txn[k][1].addr), 32'h1FFFF);
        chk("tie_second_wren",  k, 32'(g_txn[k][1].wr),   32'd0);
      end
      chk("tie_a_ready_cnt", k, 32'(rdy_cnt[k][0]), 32'd1);
      chk("tie_b_ready_cnt", k, 32'(rdy_cnt[k][1]), 32'd1);
    end

    // Continuous re-request: alternation vs fixed priority
    do_reset();
    rsp_delay = 2;
    for (int p = 0; p < 2; p++) drive_both(p, 1'b1, 21'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 80; i++) begin
      cyc();
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          if (port_req(k, p)) set_req(k, p, 1'b0);
          else if (gcount[k] < 6 && mem_req_o[k] === 1'b1 && owner_o[k] === (p == 1)) begin
            set_fields(k, p, 21'($urandom), 8'($urandom), 1'($urandom));
            set_req(k, p, 1'b1);
          end
        end
    end
    for (int k = 0; k < 2; k++) begin
      chk("rr_grant_count", k, 32'(g_own[k].size() >= 6), 32'd1);
      if (g_own[k].size() >= 6)
        for (int i = 0; i < 6; i++)
          chk("rr_order", k, 32'(g_own[k][i]), (k == 0) ? 32'(i % 2) : 32'd0);
      chk("rr_no_overrun", k, 32'({a_overrun_o[k], b_overrun_o[k]}), 32'd0);
    end

    // Overrun on B while A is in flight
    do_reset();
    rsp_delay = 15;
    drive_both(0, 1'b1, 21'h00042, 8'h00, 1'b0);
    cyc();
    req_both(0, 1'b0);
    cycles(2);
    drive_both(1, 1'b1, 21'h00111, 8'h00, 1'b0);
    cyc();
    req_both(1, 1'b0);
    cyc();
    drive_both(1, 1'b1, 21'h00222, 8'h00, 1'b0);
    cyc();
    req_both(1, 1'b0);
    cycles(30);
    chk("ovr_b_flag", 0, 32'(b_overrun_o[0]), 32'd1);
    chk("ovr_a_flag", 0, 32'(a_overrun_o[0]), 32'd0);
    chk("ovr_grants", 0, 32'(gcount[0]), 32'd2);
    if (g_txn[0].size() >= 2) chk("ovr_first_b_addr", 0, 32'(g_txn[0][1].addr), 32'h00111);

    // Held request level and a long controller stall
    do_reset();
    rsp_delay = 1000;
    drive_both(0, 1'b1, 21'h01234, 8'h00, 1'b0);
    cycles(50);
    req_both(0, 1'b0);
    cycles(940);
    chk("stall_busy",   0, 32'(busy_o[0]),  32'd1);
    chk("stall_grants", 0, 32'(gcount[0]),  32'd1);
    cycles(30);
    chk("stall_done_ready", 0, 32'(rdy_cnt[0][0]), 32'd1);
    chk("stall_done_busy",  0, 32'(busy_o[0]),     32'd0);
    chk("stall_one_grant",  0, 32'(gcount[0]),     32'd1);

    // Reset in the middle of a transaction abandons it
    do_reset();
    rsp_delay = 20;
    drive_both(0, 1'b1, 21'h00777, 8'h00, 1'b0);
    cyc();
    req_both(0, 1'b0);
    cycles(4);
    chk("mid_busy_before", 0, 32'(busy_o[0]), 32'd1);
    do_reset();
    cycles(2);
    extra_rdy = 1'b1;
    cyc();
    extra_rdy = 1'b0;
    cycles(30);
    for (int k = 0; k < 2; k++) begin
      chk("mid_no_ready", k, 32'(rdy_cnt[k][0] + rdy_cnt[k][1]), 32'd0);
      chk("mid_no_grant", k, 32'(gcount[k]), 32'd0);
      chk("mid_idle",     k, 32'(busy_o[k]), 32'd0);
    end

    // Randomized traffic against the reference model
    do_reset();
    rsp_delay = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (i == 2000) do_reset();
      from_mem_i = 8'($urandom);
      extra_rdy = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++) begin
        if (port_req(0, p)) begin
          if ($urandom_range(0, 1) == 0) req_both(p, 1'b0);
        end else if ($urandom_range(0, 5) == 0) begin
          drive_both(p, 1'b1, 21'($urandom), 8'($urandom), 1'($urandom));
        end
      end
    end
    extra_rdy = 1'b0;
    cycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
